// File: rtl/adder_subtractor.sv
// Registered signed adder/subtractor with overflow, carry, zero, negative flags.
// Define ADDSUB_SATURATE_EN to clamp overflowing results instead of wrapping.
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             carry_out,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic             ovf_next;
  logic [WIDTH-1:0] res;

  logic [WIDTH-1:0] s_q, s_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  always_comb begin
    b_eff = op ? ~b : b;
    c     = '0;
    sum   = '0;
    c[0]  = op;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a[i] & b_eff[i])
               | (c[i] & (a[i] ^ b_eff[i]));
    end
    ovf_next = c[WIDTH] ^ c[WIDTH-1];
  end

`ifdef ADDSUB_SATURATE_EN
  // On overflow a and b_eff share a sign, so a's sign picks the rail.
  always_comb begin
    res = sum;
    if (ovf_next) begin
      res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res = sum;
  end
`endif

  always_comb begin
    s_d    = s_q;
    ovf_d  = ovf_q;
    cout_d = cout_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (enable) begin
      s_d    = res;
      ovf_d  = ovf_next;
      cout_d = c[WIDTH];
      zero_d = (res == '0);
      neg_d  = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      ovf_q  <= ovf_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign s         = s_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Bench for adder_subtractor: directed table, hand sequences, random vs model.
module tb_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] a, b;
  logic       op;
  logic [7:0] s;
  logic       overflow, carry_out, zero, negative;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] s;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] m_s;
  logic       m_ovf, m_c;

  adder_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .a(a), .b(b), .op(op),
    .s(s), .overflow(overflow), .carry_out(carry_out),
    .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  // Integer-level reference: true signed result, range test, unsigned carry.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       input logic mop);
    int sa, sb, r, ua, ub;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = int'(ma);
    ub = int'(mb);
    r  = mop ? sa - sb : sa + sb;
    m_ovf = (r > 127) || (r < -128);
    m_s   = 8'(r);
    m_c   = mop ? (ua >= ub) : (ua + ub > 255);
`ifdef ADDSUB_SATURATE_EN
    if (m_ovf) m_s = (r > 0) ? 8'd127 : 8'h80;
`endif
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] es,
                         input logic eo, input logic ec);
    chk({name, ".s"}, s, es);
    chk({name, ".ovf"}, {7'd0, overflow}, {7'd0, eo});
    chk({name, ".carry"}, {7'd0, carry_out}, {7'd0, ec});
    chk({name, ".zero"}, {7'd0, zero}, {7'd0, es == 8'd0});
    chk({name, ".neg"}, {7'd0, negative}, {7'd0, es[7]});
  endtask

  task automatic step(input logic r, input logic en, input logic [7:0] ta,
                      input logic [7:0] tb, input logic top);
    rst_n  = r;
    enable = en;
    a      = ta;
    b      = tb;
    op     = top;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] es;
    logic       eo, ec;

    tbl.push_back('{8'd1,      8'd1,      1'b0, 8'd2,      1'b0});
    tbl.push_back('{8'd1,      8'd1,      1'b1, 8'd0,      1'b0});
    tbl.push_back('{8'd1,      8'(-1),    1'b0, 8'd0,      1'b0});
    tbl.push_back('{8'd1,      8'(-1),    1'b1, 8'd2,      1'b0});
    tbl.push_back('{8'(-1),    8'd1,      1'b0, 8'd0,      1'b0});
    tbl.push_back('{8'(-1),    8'd1,      1'b1, 8'(-2),    1'b0});
    tbl.push_back('{8'(-1),    8'(-1),    1'b0, 8'(-2),    1'b0});
    tbl.push_back('{8'(-1),    8'(-1),    1'b1, 8'd0,      1'b0});
    tbl.push_back('{8'd127,    8'd1,      1'b0, 8'(-128),  1'b1});
    tbl.push_back('{8'd127,    8'(-1),    1'b1, 8'(-128),  1'b1});
    tbl.push_back('{8'd127,    8'd1,      1'b1, 8'd126,    1'b0});
    tbl.push_back('{8'd127,    8'(-1),    1'b0, 8'd126,    1'b0});
    tbl.push_back('{8'(-127),  8'd1,      1'b0, 8'(-126),  1'b0});
    tbl.push_back('{8'(-127),  8'(-1),    1'b1, 8'(-126),  1'b0});
    tbl.push_back('{8'(-127),  8'd1,      1'b1, 8'(-128),  1'b0});
    tbl.push_back('{8'(-127),  8'(-1),    1'b0, 8'(-128),  1'b0});
    tbl.push_back('{8'd0,      8'(-128),  1'b1, 8'(-128),  1'b1});
    tbl.push_back('{8'(-128),  8'(-128),  1'b0, 8'd0,      1'b1});
    tbl.push_back('{8'(-128),  8'(-1),    1'b0, 8'd127,    1'b1});
    tbl.push_back('{8'd100,    8'd50,     1'b1, 8'd50,     1'b0});

    // reset held for two edges with live inputs
    step(1'b0, 1'b1, 8'd5, 8'd3, 1'b0);
    step(1'b0, 1'b1, 8'd5, 8'd3, 1'b0);
    chk_all("reset", 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd5, 8'd3, 1'b0);
    chk_all("after_reset", 8'd8, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
      model(tbl[i].a, tbl[i].b, tbl[i].op);
      es = tbl[i].s;
`ifdef ADDSUB_SATURATE_EN
      if (tbl[i].ovf) es = tbl[i].a[7] ? 8'h80 : 8'd127;
`endif
      chk($sformatf("tbl%0d", i), s, es);
      chk($sformatf("tbl%0d.ovf", i), {7'd0, overflow},
          {7'd0, tbl[i].ovf});
      chk_all($sformatf("tbl%0d.m", i), m_s, m_ovf, m_c);
    end

    // enable hold
    step(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
    chk_all("hold_pre", 8'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'd127, 8'd1, 1'b0);
      chk_all($sformatf("hold%0d", k), 8'd2, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 8'd127, 8'd1, 1'b0);
    model(8'd127, 8'd1, 1'b0);
    chk_all("hold_release", m_s, m_ovf, m_c);

    // reset discards an in-flight result, and beats enable
    step(1'b1, 1'b1, 8'(-1), 8'(-1), 1'b0);
    step(1'b0, 1'b1, 8'(-1), 8'(-1), 1'b0);
    chk_all("mid_reset", 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd9, 8'd9, 1'b0);
    chk_all("reset_then_hold", 8'd0, 1'b0, 1'b0);

    // randomized against model, tracking held state
    es = 8'd0; eo = 1'b0; ec = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic       rr, ren, rop;
      logic [7:0] ra, rb;
      rr  = ($urandom_range(0, 29) != 0);
      ren = ($urandom_range(0, 3) != 0);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 1'($urandom);
      step(rr, ren, ra, rb, rop);
      if (!rr) begin
        es = 8'd0; eo = 1'b0; ec = 1'b0;
      end else if (ren) begin
        model(ra, rb, rop);
        es = m_s; eo = m_ovf; ec = m_c;
      end
      chk_all($sformatf("rnd%0d", i), es, eo, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
